// File: rtl/graphic_sprite_engine.sv
// graphic_sprite_engine: multi-sprite road overlay. Double-buffered sprite
// attributes are committed on frame_tick. Each sprite has a 1-bit bitmap.
// A 2-stage pixel pipeline produces priority-resolved rgb/on outputs and
// per-sprite collision flags for the previous frame.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   frame_tick        start-of-vblank pulse: commit attributes, latch collisions
//   wr_en/wr_sel/...  attribute write into the pending buffer
//   bmp_we/bmp_sel/.. immediate bitmap row write (MSB = leftmost pixel)
//   video_on,pixel_x,pixel_y  current raster position
//   rgb, on           registered pixel result, 2 clk after the raster inputs
//   collision         bit i = sprite i overlapped another opaque sprite last frame
module graphic_sprite_engine #(
    parameter int N_SPR   = 4,
    parameter int SPR_W   = 16,
    parameter int SPR_H   = 32,
    parameter int ROAD_X0 = 256,
    parameter int ROAD_X1 = 511
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       frame_tick,
    input  logic                       wr_en,
    input  logic [$clog2(N_SPR)-1:0]   wr_sel,
    input  logic [9:0]                 wr_x,
    input  logic [9:0]                 wr_y,
    input  logic [2:0]                 wr_color,
    input  logic                       wr_vis,
    input  logic                       bmp_we,
    input  logic [$clog2(N_SPR)-1:0]   bmp_sel,
    input  logic [$clog2(SPR_H)-1:0]   bmp_row,
    input  logic [SPR_W-1:0]           bmp_data,
    input  logic                       video_on,
    input  logic [9:0]                 pixel_x,
    input  logic [9:0]                 pixel_y,
    output logic [2:0]                 rgb,
    output logic                       on,
    output logic [N_SPR-1:0]           collision
);

    localparam int SW  = $clog2(N_SPR);
    localparam int LXW = $clog2(SPR_W);
    localparam int LYW = $clog2(SPR_H);

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] color;
        logic       vis;
    } attr_t;

    attr_t [N_SPR-1:0] pend;
    attr_t [N_SPR-1:0] act;
    attr_t             wr_attr;

    assign wr_attr = '{x: wr_x, y: wr_y, color: wr_color, vis: wr_vis};

    // Pending buffer takes writes any time; active copies it on frame_tick.
    // A write coinciding with the tick goes straight through to active.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend <= '0;
            act  <= '0;
        end else begin
            for (int i = 0; i < N_SPR; i++) begin
                if (wr_en && wr_sel == SW'(i)) begin
                    pend[i] <= wr_attr;
                end
                if (frame_tick) begin
                    if (wr_en && wr_sel == SW'(i)) begin
                        act[i] <= wr_attr;
                    end else begin
                        act[i] <= pend[i];
                    end
                end
            end
        end
    end

    // Bitmap RAM: never reset; hidden sprites can never reach it.
    logic [SPR_W-1:0] bmp [N_SPR][SPR_H];

    always_ff @(posedge clk) begin
        if (bmp_we) begin
            bmp[bmp_sel][bmp_row] <= bmp_data;
        end
    end

    // ---------------- stage 1: bounding-box hit test ----------------
    logic [N_SPR-1:0]           hit_c;
    logic [N_SPR-1:0][LXW-1:0]  lx_c;
    logic [N_SPR-1:0][LYW-1:0]  ly_c;
    logic [N_SPR-1:0][2:0]      col_c;
    logic                       road_c;

    // Compare 11 bits wide so boxes running off the right/bottom edge
    // are clipped rather than wrapped back to column/row 0.
    always_comb begin
        hit_c = '0;
        lx_c  = '0;
        ly_c  = '0;
        col_c = '0;
        for (int i = 0; i < N_SPR; i++) begin
            hit_c[i] = act[i].vis
                && ({1'b0, pixel_x} >= {1'b0, act[i].x})
                && ({1'b0, pixel_x} < ({1'b0, act[i].x} + 11'(SPR_W)))
                && ({1'b0, pixel_y} >= {1'b0, act[i].y})
                && ({1'b0, pixel_y} < ({1'b0, act[i].y} + 11'(SPR_H)));
            lx_c[i]  = LXW'(pixel_x - act[i].x);
            ly_c[i]  = LYW'(pixel_y - act[i].y);
            col_c[i] = act[i].color;
        end
    end

    assign road_c = video_on
        && (pixel_x >= 10'(ROAD_X0))
        && (pixel_x <= 10'(ROAD_X1));

    logic [N_SPR-1:0]           s1_hit;
    logic [N_SPR-1:0][LXW-1:0]  s1_lx;
    logic [N_SPR-1:0][LYW-1:0]  s1_ly;
    logic [N_SPR-1:0][2:0]      s1_color;
    logic                       s1_road;

    // Colour travels with the hit so in-flight pixels keep the
    // attributes they sampled across a commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_hit   <= '0;
            s1_lx    <= '0;
            s1_ly    <= '0;
            s1_color <= '0;
            s1_road  <= 1'b0;
        end else begin
            s1_hit   <= hit_c;
            s1_lx    <= lx_c;
            s1_ly    <= ly_c;
            s1_color <= col_c;
            s1_road  <= road_c;
        end
    end

    // ---------------- stage 2: bitmap lookup and resolve ----------------
    logic [N_SPR-1:0] opq_c;
    logic [SPR_W-1:0] row_v;
    logic [2:0]       rgb_c;
    logic             multi_c;

    // With SPR_W a power of 2, ~lx equals SPR_W-1-lx (MSB = leftmost).
    always_comb begin
        opq_c = '0;
        row_v = '0;
        for (int i = 0; i < N_SPR; i++) begin
            row_v    = bmp[i][s1_ly[i]];
            opq_c[i] = s1_hit[i] && s1_road && row_v[~s1_lx[i]];
        end
    end

    // Walk from lowest priority upward so index 0 wins last.
    always_comb begin
        rgb_c = '0;
        for (int i = N_SPR - 1; i >= 0; i--) begin
            if (opq_c[i]) begin
                rgb_c = s1_color[i];
            end
        end
    end

    // Two or more bits set: clearing the lowest set bit leaves a residue.
    assign multi_c = (opq_c & (opq_c - 1'b1)) != '0;

    logic [N_SPR-1:0] coll_acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb <= '0;
            on  <= 1'b0;
        end else begin
            rgb <= rgb_c;
            on  <= |opq_c;
        end
    end

    // Overlaps seen in the tick cycle itself belong to the new frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            coll_acc  <= '0;
            collision <= '0;
        end else if (frame_tick) begin
            collision <= coll_acc;
            coll_acc  <= multi_c ? opq_c : '0;
        end else if (multi_c) begin
            coll_acc  <= coll_acc | opq_c;
        end
    end

endmodule

// File: tb/tb_graphic_sprite_engine.sv
// Testbench for graphic_sprite_engine: directed scenarios plus random
// raster/attribute traffic against a per-pixel reference model.
module tb_graphic_sprite_engine;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, frame_tick, wr_en, wr_vis, bmp_we, video_on;
    logic [1:0]  wr_sel, bmp_sel;
    logic [9:0]  wr_x, wr_y, pixel_x, pixel_y;
    logic [2:0]  wr_color, rgb;
    logic [4:0]  bmp_row;
    logic [15:0] bmp_data;
    logic        on;
    logic [3:0]  collision;

    graphic_sprite_engine dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_x(wr_x), .wr_y(wr_y),
        .wr_color(wr_color), .wr_vis(wr_vis),
        .bmp_we(bmp_we), .bmp_sel(bmp_sel), .bmp_row(bmp_row),
        .bmp_data(bmp_data), .video_on(video_on),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .rgb(rgb), .on(on), .collision(collision)
    );

    // reference model state
    int          p_x[N], p_y[N], p_c[N], a_x[N], a_y[N], a_c[N];
    bit          p_v[N], a_v[N];
    logic [15:0] m_bmp[N][32];
    logic [3:0]  p1_opq, o_opq, acc, coll;
    logic [2:0]  p1_rgb, o_rgb;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Which sprites show an opaque road pixel at (px,py), and the colour
    // of the highest-priority one.
    function automatic void eval(input int px, input int py, input bit vo,
                                 output logic [3:0] opq, output logic [2:0] col);
        opq = '0;
        col = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (a_v[i] && vo && px >= 256 && px <= 511
                && px >= a_x[i] && px < a_x[i] + 16
                && py >= a_y[i] && py < a_y[i] + 32) begin
                if (m_bmp[i][py - a_y[i]][15 - (px - a_x[i])]) begin
                    opq[i] = 1'b1;
                    col    = 3'(a_c[i]);
                end
            end
        end
    endfunction

    task automatic cyc();
        logic [3:0] n_opq;
        logic [2:0] n_rgb;
        bit multi;
        eval(int'(pixel_x), int'(pixel_y), video_on, n_opq, n_rgb);
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                p_x[i] = 0; p_y[i] = 0; p_c[i] = 0; p_v[i] = 0;
                a_x[i] = 0; a_y[i] = 0; a_c[i] = 0; a_v[i] = 0;
            end
            p1_opq = '0; p1_rgb = '0; o_opq = '0; o_rgb = '0;
            acc = '0; coll = '0;
        end else begin
            o_opq = p1_opq;
            o_rgb = p1_rgb;
            multi = $countones(p1_opq) >= 2;
            if (frame_tick) begin
                coll = acc;
                acc  = multi ? p1_opq : 4'b0;
            end else if (multi) begin
                acc = acc | p1_opq;
            end
            p1_opq = n_opq;
            p1_rgb = n_rgb;
            if (wr_en) begin
                p_x[wr_sel] = int'(wr_x);
                p_y[wr_sel] = int'(wr_y);
                p_c[wr_sel] = int'(wr_color);
                p_v[wr_sel] = wr_vis;
            end
            if (frame_tick) begin
                for (int i = 0; i < N; i++) begin
                    a_x[i] = p_x[i]; a_y[i] = p_y[i];
                    a_c[i] = p_c[i]; a_v[i] = p_v[i];
                end
            end
        end
        if (bmp_we) m_bmp[bmp_sel][bmp_row] = bmp_data;
        #1;
        check("on", 32'(on), 32'(|o_opq));
        check("rgb", 32'(rgb), 32'(o_rgb));
        check("collision", 32'(collision), 32'(coll));
        wr_en = 1'b0;
        frame_tick = 1'b0;
        bmp_we = 1'b0;
    endtask

    task automatic wr(int s, int x, int y, int c, bit v, bit tk);
        wr_en = 1'b1; wr_sel = 2'(s); wr_x = 10'(x); wr_y = 10'(y);
        wr_color = 3'(c); wr_vis = v; frame_tick = tk;
        video_on = 1'b0;
        cyc();
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        video_on = 1'b0;
        cyc();
    endtask

    task automatic bmpw(int s, int r, logic [15:0] d);
        bmp_we = 1'b1; bmp_sel = 2'(s); bmp_row = 5'(r); bmp_data = d;
        video_on = 1'b0;
        cyc();
    endtask

    task automatic probe(string tag, int x, int y, bit vo,
                         bit exp_on, logic [2:0] exp_rgb);
        pixel_x = 10'(x); pixel_y = 10'(y); video_on = vo;
        cyc();
        video_on = 1'b0;
        cyc();
        check({tag, ".on"}, 32'(on), 32'(exp_on));
        check({tag, ".rgb"}, 32'(rgb), 32'(exp_rgb));
    endtask

    initial begin
        reset = 1'b1; frame_tick = 0; wr_en = 0; wr_sel = 0; wr_x = 0;
        wr_y = 0; wr_color = 0; wr_vis = 0; bmp_we = 0; bmp_sel = 0;
        bmp_row = 0; bmp_data = 0; video_on = 0; pixel_x = 0; pixel_y = 0;
        cyc();
        cyc();
        check("reset.on", 32'(on), 32'(0));
        check("reset.coll", 32'(collision), 32'(0));
        reset = 1'b0;

        // T1: everything hidden, sweep the raster
        for (int y = 0; y < 1024; y += 61) begin
            for (int x = 0; x < 1024; x += 29) begin
                pixel_x = 10'(x); pixel_y = 10'(y); video_on = 1'b1;
                cyc();
            end
        end
        check("t1.coll", 32'(collision), 32'(0));

        for (int r = 0; r < 32; r++) begin
            bmpw(0, r, 16'hFFFF);
            bmpw(1, r, 16'hFFFF);
            bmpw(2, r, 16'hFFFF);
            bmpw(3, r, 16'($urandom));
        end

        // T2: commit on frame_tick only
        wr(0, 300, 100, 3'b100, 1'b1, 1'b0);
        probe("t2.pre", 300, 100, 1'b1, 1'b0, 3'b000);
        tick();
        probe("t2.hit", 300, 100, 1'b1, 1'b1, 3'b100);
        probe("t2.xend", 316, 100, 1'b1, 1'b0, 3'b000);
        probe("t2.yend", 300, 132, 1'b1, 1'b0, 3'b000);
        probe("t2.xpre", 299, 100, 1'b1, 1'b0, 3'b000);

        // T3: transparency
        bmpw(0, 5, 16'h8000);
        probe("t3.opq", 300, 105, 1'b1, 1'b1, 3'b100);
        probe("t3.clr", 301, 105, 1'b1, 1'b0, 3'b000);
        bmpw(0, 5, 16'hFFFF);

        // T4: road clipping and video_on gating
        wr(0, 500, 100, 3'b100, 1'b1, 1'b1);
        probe("t4.last", 511, 110, 1'b1, 1'b1, 3'b100);
        probe("t4.off", 512, 110, 1'b1, 1'b0, 3'b000);
        probe("t4.blank", 505, 110, 1'b0, 1'b0, 3'b000);

        // T5: priority and collision
        wr(0, 300, 100, 3'b100, 1'b1, 1'b0);
        wr(1, 308, 110, 3'b010, 1'b1, 1'b0);
        tick();
        probe("t5.both", 310, 112, 1'b1, 1'b1, 3'b100);
        probe("t5.s1", 320, 120, 1'b1, 1'b1, 3'b010);
        tick();
        check("t5.coll", 32'(collision), 32'(4'b0011));
        wr(1, 400, 110, 3'b010, 1'b1, 1'b0);
        tick();
        probe("t5.s0", 310, 112, 1'b1, 1'b1, 3'b100);
        probe("t5.moved", 405, 115, 1'b1, 1'b1, 3'b010);
        tick();
        check("t5.clear", 32'(collision), 32'(0));

        // T6: write with tick, then mid-line reset
        wr(2, 350, 100, 3'b001, 1'b1, 1'b1);
        probe("t6.same", 355, 105, 1'b1, 1'b1, 3'b001);
        pixel_x = 10'd355; pixel_y = 10'd105; video_on = 1'b1;
        cyc();
        cyc();
        check("t6.live", 32'(on), 32'(1));
        reset = 1'b1;
        cyc();
        check("t6.rst.on", 32'(on), 32'(0));
        check("t6.rst.coll", 32'(collision), 32'(0));
        reset = 1'b0;
        probe("t6.after", 355, 105, 1'b1, 1'b0, 3'b000);

        // random traffic
        for (int r = 0; r < 32; r++) bmpw(1, r, 16'($urandom));
        for (int k = 0; k < 4000; k++) begin
            pixel_x = 10'($urandom_range(530, 240));
            pixel_y = 10'($urandom_range(170, 60));
            if ($urandom_range(15, 0) == 0) pixel_y = 10'($urandom_range(15, 0));
            video_on = ($urandom_range(9, 0) != 0);
            if ($urandom_range(15, 0) == 0) begin
                wr_en = 1'b1;
                wr_sel = 2'($urandom_range(3, 0));
                wr_x = 10'($urandom_range(520, 240));
                wr_y = 10'($urandom_range(160, 60));
                if ($urandom_range(7, 0) == 0) wr_y = 10'($urandom_range(1023, 1005));
                wr_color = 3'($urandom);
                wr_vis = ($urandom_range(4, 0) != 0);
            end
            frame_tick = ($urandom_range(99, 0) < 3);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
